// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: shared format codes, opcodes and request record for the instruction encoder
package imm_encoder_pkg;
   localparam logic [2:0] FMT_I = 3'b000;
   localparam logic [2:0] FMT_S = 3'b001;
   localparam logic [2:0] FMT_B = 3'b010;
   localparam logic [2:0] FMT_J = 3'b011;
   localparam logic [2:0] FMT_U = 3'b100;
   localparam logic [2:0] FMT_R = 3'b111;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } req_t;
endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational RV32I field packer with immediate range/alignment check
//   fmt/opcode/rd/rs1/rs2/funct3/funct7/imm in -> instr (NOP when illegal), err
module imm_pack
   import imm_encoder_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        err
);
   logic sx11, sx12, sx20, ok;
   logic [31:0] word;
   // an immediate fits in N+1 signed bits when everything above bit N copies the sign
   assign sx11 = &imm[31:11] | ~|imm[31:11];
   assign sx12 = &imm[31:12] | ~|imm[31:12];
   assign sx20 = &imm[31:20] | ~|imm[31:20];
   assign ok = (fmt == FMT_I || fmt == FMT_S) ? sx11 :
               fmt == FMT_B ? sx12 && !imm[0] :
               fmt == FMT_J ? sx20 && !imm[0] :
               fmt == FMT_U ? ~|imm[11:0] :
               fmt == FMT_R;
   assign word = fmt == FMT_I ? {imm[11:0], rs1, funct3, rd, opcode} :
                 fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                 fmt == FMT_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
                 fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} :
                 fmt == FMT_U ? {imm[31:12], rd, opcode} :
                 {funct7, rs2, rs1, funct3, rd, opcode};
   assign err = !ok;
   assign instr = ok ? word : NOP_INSTR;
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline packing instruction fields into addressed RV32I words
//   in_*: request fields and handshake; out_*: packed word, error flag, byte address;
//   clr flushes the pipeline and counters; err_cnt counts emitted NOP substitutions (saturating)
module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic              out_err,
   output logic [ADDR_W-1:0] out_addr,
   output logic [CNT_W-1:0]  err_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   req_t s1_req;
   logic s1_v, s1_adv, s2_adv, acc, pk_err;
   logic [31:0] pk_instr;
   // S1 holds raw fields; legality and packing are evaluated on them and captured into S2
   imm_pack u_pack (
      .fmt(s1_req.fmt), .opcode(s1_req.opcode), .rd(s1_req.rd), .rs1(s1_req.rs1),
      .rs2(s1_req.rs2), .funct3(s1_req.funct3), .funct7(s1_req.funct7), .imm(s1_req.imm),
      .instr(pk_instr), .err(pk_err)
   );
   assign s2_adv = !out_valid || out_ready;
   assign s1_adv = s1_v && s2_adv;
   assign in_ready = reset_n && !clr && (!s1_v || s1_adv);
   assign acc = in_valid && in_ready;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         s1_v <= 1'b0;
         s1_req <= '0;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_err <= 1'b0;
         out_addr <= BASE_ADDR;
         err_cnt <= '0;
      end else if (clr) begin
         s1_v <= 1'b0;
         out_valid <= 1'b0;
         out_err <= 1'b0;
         out_addr <= BASE_ADDR;
         err_cnt <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_addr <= out_addr + ADDR_W'(4);
            if (out_err && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
         end
         if (s2_adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
               out_instr <= pk_instr;
               out_err <= pk_err;
            end
         end
         if (acc) begin
            s1_v <= 1'b1;
            s1_req <= '{in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm};
         end else if (s1_adv) s1_v <= 1'b0;
      end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed checks of imm_encoder against an arithmetic reference model
module tb_imm_encoder;
   import imm_encoder_pkg::*;
   logic clk, reset_n, clr, in_valid, out_ready;
   logic [2:0] in_fmt, in_funct3;
   logic [6:0] in_opcode, in_funct7;
   logic [4:0] in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic in_ready, out_valid, out_err;
   logic [31:0] out_instr, out_addr;
   logic [7:0] err_cnt;
   logic in_ready2, out_valid2, out_err2;
   logic [31:0] out_instr2;
   logic [3:0] out_addr2;
   logic [1:0] err_cnt2;
   int errors = 0, checks = 0, acc_n = 0;
   logic [32:0] exp_q[$];
   logic [64:0] got_q[$];
   logic [3:0] got2_q[$];

   imm_encoder dut (
      .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err), .out_addr(out_addr),
      .err_cnt(err_cnt)
   );
   imm_encoder #(.ADDR_W(4), .CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid2),
      .out_ready(out_ready), .out_instr(out_instr2), .out_err(out_err2), .out_addr(out_addr2),
      .err_cnt(err_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: legality from signed ranges and divisibility, fields placed per RV32I layout
   function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
         input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
      int s = $signed(imm);
      bit ok = 0;
      logic [31:0] w = '0;
      case (f)
         3'b000: begin ok = s >= -2048 && s <= 2047; w = {imm[11:0], r1, f3, rd, op}; end
         3'b001: begin ok = s >= -2048 && s <= 2047; w = {imm[11:5], r2, r1, f3, imm[4:0], op}; end
         3'b010: begin ok = s >= -4096 && s <= 4095 && s % 2 == 0; w = {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], op}; end
         3'b011: begin ok = s >= -1048576 && s <= 1048575 && s % 2 == 0; w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; end
         3'b100: begin ok = imm % 4096 == 0; w = {imm[31:12], rd, op}; end
         3'b111: begin ok = 1; w = {f7, r2, r1, f3, rd, op}; end
         default: ok = 0;
      endcase
      return ok ? {1'b0, w} : {1'b1, 32'h00000013};
   endfunction

   // one clock: record accepted requests and delivered words, then land on the next falling edge
   task automatic tick();
      #1;
      if (in_valid && in_ready) begin
         exp_q.push_back(model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
         acc_n++;
      end
      if (out_valid && out_ready && !clr) got_q.push_back({out_err, out_addr, out_instr});
      if (out_valid2 && out_ready && !clr) got2_q.push_back(out_addr2);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_model();
      exp_q.delete();
      got_q.delete();
      got2_q.delete();
   endtask

   task automatic flush();
      in_valid = 0;
      clr = 1;
      tick();
      clr = 0;
      clear_model();
   endtask

   task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
         input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3, input logic [6:0] f7,
         input logic [31:0] imm);
      in_fmt = f; in_opcode = op; in_rd = d; in_rs1 = r1; in_rs2 = r2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
   endtask

   task automatic rand_req();
      int m = $urandom_range(0, 3);
      logic [31:0] v;
      case (m)
         0: v = 32'($urandom_range(0, 8191)) - 32'd4096;
         1: v = $urandom;
         2: v = $urandom & 32'hFFFFF000;
         default: v = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), v);
   endtask

   task automatic test_reset();
      reset_n = 0; clr = 0; in_valid = 0; out_ready = 0;
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", out_instr); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", out_err); end
      checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", out_addr); end
      checks++; if (err_cnt !== 8'h0) begin errors++; $display("FAIL reset_cnt got %0d want 0", err_cnt); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      reset_n = 1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [2:0] f[4] = '{FMT_I, FMT_B, FMT_J, FMT_U};
      logic [6:0] op[4] = '{OP_IMM, OP_BRANCH, OP_JAL, OP_LUI};
      logic [4:0] rd[4] = '{5, 0, 1, 3};
      logic [4:0] r1[4] = '{0, 1, 0, 0};
      logic [4:0] r2[4] = '{0, 2, 0, 0};
      logic [31:0] imm[4] = '{32'hFFFFFFFF, 32'd8, 32'h800, 32'h12345000};
      logic [31:0] want[4] = '{32'hFFF00293, 32'h00208463, 32'h001000EF, 32'h123451B7};
      logic [32:0] m;
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         set_req(f[i], op[i], rd[i], r1[i], r2[i], 3'd0, 7'd0, imm[i]);
         m = model(f[i], op[i], rd[i], r1[i], r2[i], 3'd0, 7'd0, imm[i]);
         in_valid = 1;
         tick();
         in_valid = 0;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency[%0d] out_valid got %b want 0", i, out_valid); end
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b want 1", i, out_valid); end
         checks++; if (out_instr !== want[i]) begin errors++; $display("FAIL basic_instr[%0d] got %h want %h", i, out_instr, want[i]); end
         checks++; if (out_instr !== m[31:0]) begin errors++; $display("FAIL basic_model[%0d] got %h want %h", i, out_instr, m[31:0]); end
         checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err[%0d] got %b want 0", i, out_err); end
         checks++; if (out_addr !== 32'(4 * i)) begin errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, out_addr, 4 * i); end
         tick();
      end
   endtask

   task automatic test_errors();
      logic [2:0] f[4] = '{FMT_B, FMT_U, FMT_I, 3'b101};
      logic [31:0] imm[4] = '{32'd3, 32'h12345001, 32'd2048, 32'd0};
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         set_req(f[i], OP_IMM, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, imm[i]);
         in_valid = 1;
         tick();
         in_valid = 0;
         tick();
         checks++; if (out_instr !== NOP_INSTR) begin errors++; $display("FAIL err_instr[%0d] got %h want 00000013", i, out_instr); end
         checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL err_flag[%0d] got %b want 1", i, out_err); end
         tick();
         checks++; if (err_cnt !== 8'(i + 1)) begin errors++; $display("FAIL err_cnt[%0d] got %0d want %0d", i, err_cnt, i + 1); end
      end
   endtask

   task automatic test_backpressure();
      int base, last;
      logic [31:0] h_instr, h_addr;
      flush();
      out_ready = 0;
      base = acc_n;
      last = -1;
      for (int c = 0; c < 5; c++) begin
         if (acc_n - base != last && acc_n - base < 4) begin rand_req(); last = acc_n - base; end
         in_valid = acc_n - base < 4;
         tick();
         if (c == 1) begin h_instr = out_instr; h_addr = out_addr; end
         if (c >= 2) begin
            checks++; if (out_valid !== 1'b1 || out_instr !== h_instr || out_addr !== h_addr) begin
               errors++; $display("FAIL bp_hold[%0d] got v=%b %h@%h want v=1 %h@%h", c, out_valid, out_instr, out_addr, h_instr, h_addr);
            end
         end
      end
      checks++; if (acc_n - base != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", acc_n - base); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      out_ready = 1;
      for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
         if (acc_n - base != last && acc_n - base < 4) begin rand_req(); last = acc_n - base; end
         in_valid = acc_n - base < 4;
         tick();
      end
      in_valid = 0;
      checks++; if (got_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== {exp_q[i][32], 32'(4 * i), exp_q[i][31:0]}) begin
            errors++; $display("FAIL bp_word[%0d] got %h want %h", i, got_q[i], {exp_q[i][32], 32'(4 * i), exp_q[i][31:0]});
         end
      end
   endtask

   task automatic test_random();
      int n_err = 0;
      flush();
      for (int c = 0; c < 400; c++) begin
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         rand_req();
         tick();
      end
      in_valid = 0;
      out_ready = 1;
      for (int c = 0; c < 20 && got_q.size() < exp_q.size(); c++) tick();
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         if (exp_q[i][32]) n_err++;
         checks++; if (got_q[i] !== {exp_q[i][32], 32'(4 * i), exp_q[i][31:0]}) begin
            errors++; $display("FAIL rand_word[%0d] got %h want %h", i, got_q[i], {exp_q[i][32], 32'(4 * i), exp_q[i][31:0]});
         end
      end
      if (n_err > 255) n_err = 255;
      checks++; if (err_cnt !== 8'(n_err)) begin errors++; $display("FAIL rand_err_cnt got %0d want %0d", err_cnt, n_err); end
   endtask

   task automatic test_wrap_sat();
      logic [3:0] want[5] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0};
      flush();
      out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         set_req(i < 5 ? FMT_R : 3'b101, OP_REG, 5'(i), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
         in_valid = 1;
         tick();
      end
      in_valid = 0;
      repeat (3) tick();
      checks++; if (got2_q.size() != 10) begin errors++; $display("FAIL wrap_count got %0d want 10", got2_q.size()); end
      for (int i = 0; i < 5 && i < got2_q.size(); i++) begin
         checks++; if (got2_q[i] !== want[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, got2_q[i], want[i]); end
      end
      checks++; if (err_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt got %0d want 3", err_cnt2); end
      checks++; if (err_cnt !== 8'd5) begin errors++; $display("FAIL wide_cnt got %0d want 5", err_cnt); end
   endtask

   task automatic test_clr();
      flush();
      out_ready = 1;
      set_req(3'b110, OP_IMM, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
      in_valid = 1;
      tick();
      in_valid = 0;
      repeat (2) tick();
      checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL clr_pre_cnt got %0d want 1", err_cnt); end
      out_ready = 0;
      in_valid = 1;
      for (int c = 0; c < 3; c++) begin
         set_req(FMT_R, OP_REG, 5'(c), 5'd3, 5'd4, 3'd0, 7'd0, 32'd0);
         tick();
      end
      in_valid = 0;
      #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_addr !== 32'd4) begin
         errors++; $display("FAIL clr_full got v=%b rdy=%b addr=%h want v=1 rdy=0 addr=4", out_valid, in_ready, out_addr);
      end
      @(negedge clk);
      clr = 1;
      out_ready = 1;
      tick();
      clr = 0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b want 0", out_valid); end
      checks++; if (out_addr !== 32'd0) begin errors++; $display("FAIL clr_addr got %h want 0", out_addr); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", err_cnt); end
      repeat (3) tick();
      checks++; if (out_valid !== 1'b0 || got_q.size() != 1) begin
         errors++; $display("FAIL clr_drop got v=%b words=%0d want v=0 words=1", out_valid, got_q.size());
      end
      clear_model();
   endtask

   task automatic test_async_reset();
      out_ready = 1;
      in_valid = 1;
      for (int c = 0; c < 3; c++) begin
         set_req(FMT_R, OP_REG, 5'(c + 1), 5'd5, 5'd6, 3'd0, 7'd0, 32'd0);
         tick();
      end
      in_valid = 0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b want 1", out_valid); end
      #2;
      reset_n = 0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0) begin
         errors++; $display("FAIL ar_outputs got v=%b instr=%h err=%b want 0", out_valid, out_instr, out_err);
      end
      checks++; if (out_addr !== 32'h0 || err_cnt !== 8'h0) begin
         errors++; $display("FAIL ar_counters got addr=%h cnt=%0d want 0", out_addr, err_cnt);
      end
      @(negedge clk);
      reset_n = 1;
      clear_model();
      set_req(FMT_I, OP_IMM, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, 32'd100);
      in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_addr !== 32'h0 || out_instr !== 32'h06440393) begin
         errors++; $display("FAIL ar_first got v=%b %h@%h want v=1 06440393@0", out_valid, out_instr, out_addr);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_errors();
      test_backpressure();
      test_random();
      test_wrap_sat();
      test_clr();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
